rps_match_controller: RTL and testbench
=======================================

RPS_MATCH_CONTROLLER -- requirements
Module: rps_match_controller

Interface
REQ-001 Parameter ROUND_CYCLES, default 4687500: length of one move window in clk cycles.
REQ-002 Parameter SHOW_CYCLES, default 1171875: result display pause between rounds, in cycles.
REQ-003 Parameter WIN_SCORE, default 3: points needed to win the match.
REQ-004 Parameter MAX_ROUNDS, default 9: hard round limit per match.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 start  input  1  level, sampled in IDLE and DONE; begins a new match.
REQ-008 p1_valid / p2_valid  input  1 each  player move offered.
REQ-009 p1_move / p2_move  input  2 each  00 rock, 01 paper, 10 scissors, 11 illegal.
REQ-010 p1_ack / p2_ack  output  1 each  combinational; move accepted this cycle.
REQ-011 round_active  output  1  high in ROUND state.
REQ-012 time_left  output  26  remaining window cycles; zero outside ROUND.
REQ-013 result_valid  output  1  one-cycle pulse per resolved round.
REQ-014 result  output  2  00 tie, 01 P1 wins round, 10 P2 wins round; held until next result_valid.
REQ-015 p1_score / p2_score  output  4 each  match points.
REQ-016 round_num  output  4  rounds resolved in current match.
REQ-017 match_done  output  1  high in DONE.
REQ-018 winner  output  2  00 draw, 01 P1, 10 P2; valid while match_done.

Function
REQ-019 States IDLE, ROUND, RESOLVE, SHOW, DONE; one-hot or binary encoding is an implementation choice.
REQ-020 IDLE: start=1 -> ROUND next cycle; scores, round_num, result cleared; time_left loads ROUND_CYCLES-1.
REQ-021 ROUND: time_left decrements by 1 each cycle; no wrap below 0.
REQ-022 Move accept: pX_ack = pX_valid & (state==ROUND) & no move latched for X & pX_move!=11; on ack, move latched.
REQ-023 Illegal code 11 never acked; repeated valid after latch never acked; valid outside ROUND ignored.
REQ-024 Both moves latched (including both in the same cycle) -> RESOLVE next cycle.
REQ-025 time_left==0 and not both latched -> RESOLVE next cycle; a move acked in that same cycle counts.
REQ-026 RESOLVE (exactly 1 cycle): result_valid=1; rock>scissors, scissors>paper, paper>rock, equal moves tie; one missing move forfeits to the other player; both missing = tie.
REQ-027 RESOLVE: winning player's score +1, round_num +1, both latched moves cleared; registered outputs visible next cycle.
REQ-028 SHOW: counts SHOW_CYCLES cycles, then -> DONE if either score==WIN_SCORE or round_num==MAX_ROUNDS, else -> ROUND with time_left reloaded to ROUND_CYCLES-1.
REQ-029 DONE: match_done=1; winner = higher score, draw if equal; scores and result held.
REQ-030 DONE: start=1 -> clears scores/round_num/result, -> ROUND next cycle (same as REQ-020).
REQ-031 start ignored in ROUND, RESOLVE, SHOW.
REQ-032 Counters sized from parameters; scores cannot exceed WIN_SCORE.

Reset
REQ-033 reset=1 at a clock edge -> IDLE, all outputs 0, latched moves cleared, counters 0; overrides all other inputs, including mid-ROUND or mid-SHOW.

Verification
(Bench parameters: ROUND_CYCLES=8, SHOW_CYCLES=2, WIN_SCORE=2, MAX_ROUNDS=4.)
REQ-034 Normal round: start; P1 rock at cycle 2, P2 scissors at cycle 3 -> acks one cycle each, RESOLVE at cycle 4, result=01, p1_score=1, round_num=1.
REQ-035 Timeout forfeit: only P2 paper offered -> time_left 7..0, result=10 pulse after the cycle with time_left=0, p2_score=1; both silent -> result=00, scores unchanged.
REQ-036 Handshake rules: P1 move=11 -> no ack; P1 valid held 5 cycles -> single ack; simultaneous valid from both -> both acks same cycle, RESOLVE next.
REQ-037 Match end: P1 wins two rounds -> match_done=1, winner=01 after SHOW; four ties -> DONE at round_num=4, winner=00; start in DONE -> scores 0, ROUND.
REQ-038 Reset mid-ROUND with P1 move latched -> IDLE, all outputs 0; following start -> new match with no stale move.

Source files
------------

// File: rtl/rps_match_controller.sv
// Rock-paper-scissors match controller.
// Runs timed move windows, resolves each round, shows the result for a
// fixed pause and ends the match on a winning score or the round limit.
module rps_match_controller #(
    parameter int unsigned ROUND_CYCLES = 4687500,
    parameter int unsigned SHOW_CYCLES  = 1171875,
    parameter int unsigned WIN_SCORE    = 3,
    parameter int unsigned MAX_ROUNDS   = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        p1_valid,
    input  logic        p2_valid,
    input  logic [1:0]  p1_move,
    input  logic [1:0]  p2_move,
    output logic        p1_ack,
    output logic        p2_ack,
    output logic        round_active,
    output logic [25:0] time_left,
    output logic        result_valid,
    output logic [1:0]  result,
    output logic [3:0]  p1_score,
    output logic [3:0]  p2_score,
    output logic [3:0]  round_num,
    output logic        match_done,
    output logic [1:0]  winner
);

    localparam int unsigned SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [25:0]   TL_LOAD   = 26'(ROUND_CYCLES - 1);
    localparam logic [SW-1:0] SHOW_LOAD = SW'(SHOW_CYCLES - 1);
    localparam logic [3:0]    WIN_Q     = 4'(WIN_SCORE);
    localparam logic [3:0]    MAX_Q     = 4'(MAX_ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE, S_ROUND, S_RESOLVE, S_SHOW, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [25:0]   time_left_q, time_left_d;
    logic [SW-1:0] show_cnt_q, show_cnt_d;
    logic          p1_have_q, p1_have_d, p2_have_q, p2_have_d;
    logic [1:0]    p1_mv_q, p1_mv_d, p2_mv_q, p2_mv_d;
    logic [1:0]    result_q, result_d;
    logic [3:0]    p1_score_q, p1_score_d, p2_score_q, p2_score_d;
    logic [3:0]    round_num_q, round_num_d;
    logic [1:0]    winner_q, winner_d;

    // Round outcome: 00 tie, 01 P1, 10 P2; a missing move forfeits.
    function automatic logic [1:0] judge(input logic h1, input logic [1:0] m1,
                                         input logic h2, input logic [1:0] m2);
        if (h1 && h2) begin
            if (m1 == m2) return 2'b00;
            if ((m1 == 2'b00 && m2 == 2'b10) || (m1 == 2'b01 && m2 == 2'b00) ||
                (m1 == 2'b10 && m2 == 2'b01)) return 2'b01;
            return 2'b10;
        end
        if (h1) return 2'b01;
        if (h2) return 2'b10;
        return 2'b00;
    endfunction

    // Next-state, move handshake and score bookkeeping.
    always_comb begin
        state_d     = state_q;
        time_left_d = time_left_q;
        show_cnt_d  = show_cnt_q;
        p1_have_d   = p1_have_q;
        p2_have_d   = p2_have_q;
        p1_mv_d     = p1_mv_q;
        p2_mv_d     = p2_mv_q;
        result_d    = result_q;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        round_num_d = round_num_q;
        winner_d    = winner_q;

        p1_ack = p1_valid && (state_q == S_ROUND) && !p1_have_q && (p1_move != 2'b11);
        p2_ack = p2_valid && (state_q == S_ROUND) && !p2_have_q && (p2_move != 2'b11);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_ROUND;
                    time_left_d = TL_LOAD;
                    p1_have_d   = 1'b0;
                    p2_have_d   = 1'b0;
                    result_d    = '0;
                    p1_score_d  = '0;
                    p2_score_d  = '0;
                    round_num_d = '0;
                    winner_d    = '0;
                end
            end
            S_ROUND: begin
                if (p1_ack) begin
                    p1_have_d = 1'b1;
                    p1_mv_d   = p1_move;
                end
                if (p2_ack) begin
                    p2_have_d = 1'b1;
                    p2_mv_d   = p2_move;
                end
                time_left_d = (time_left_q == '0) ? '0 : time_left_q - 26'd1;
                // Result is registered on the way into RESOLVE so it is
                // already on the port while result_valid is high.
                if ((p1_have_d && p2_have_d) || (time_left_q == '0)) begin
                    state_d     = S_RESOLVE;
                    time_left_d = '0;
                    result_d    = judge(p1_have_d, p1_mv_d, p2_have_d, p2_mv_d);
                end
            end
            S_RESOLVE: begin
                if (result_q == 2'b01 && p1_score_q < WIN_Q) p1_score_d = p1_score_q + 4'd1;
                if (result_q == 2'b10 && p2_score_q < WIN_Q) p2_score_d = p2_score_q + 4'd1;
                round_num_d = round_num_q + 4'd1;
                p1_have_d   = 1'b0;
                p2_have_d   = 1'b0;
                show_cnt_d  = SHOW_LOAD;
                state_d     = S_SHOW;
            end
            S_SHOW: begin
                if (show_cnt_q == '0) begin
                    if (p1_score_q == WIN_Q || p2_score_q == WIN_Q || round_num_q == MAX_Q) begin
                        state_d  = S_DONE;
                        winner_d = (p1_score_q > p2_score_q) ? 2'b01 :
                                   (p2_score_q > p1_score_q) ? 2'b10 : 2'b00;
                    end else begin
                        state_d     = S_ROUND;
                        time_left_d = TL_LOAD;
                    end
                end else begin
                    show_cnt_d = show_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Single register stage for all controller state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            time_left_q <= '0;
            show_cnt_q  <= '0;
            p1_have_q   <= 1'b0;
            p2_have_q   <= 1'b0;
            p1_mv_q     <= '0;
            p2_mv_q     <= '0;
            result_q    <= '0;
            p1_score_q  <= '0;
            p2_score_q  <= '0;
            round_num_q <= '0;
            winner_q    <= '0;
        end else begin
            state_q     <= state_d;
            time_left_q <= time_left_d;
            show_cnt_q  <= show_cnt_d;
            p1_have_q   <= p1_have_d;
            p2_have_q   <= p2_have_d;
            p1_mv_q     <= p1_mv_d;
            p2_mv_q     <= p2_mv_d;
            result_q    <= result_d;
            p1_score_q  <= p1_score_d;
            p2_score_q  <= p2_score_d;
            round_num_q <= round_num_d;
            winner_q    <= winner_d;
        end
    end

    assign round_active = (state_q == S_ROUND);
    assign result_valid = (state_q == S_RESOLVE);
    assign match_done   = (state_q == S_DONE);
    assign time_left    = time_left_q;
    assign result       = result_q;
    assign p1_score     = p1_score_q;
    assign p2_score     = p2_score_q;
    assign round_num    = round_num_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_rps_match_controller.sv
// Self-checking bench for rps_match_controller with a round-level reference model.
module tb_rps_match_controller;

    localparam int unsigned RC = 8;
    localparam int unsigned SC = 2;
    localparam int unsigned WS = 2;
    localparam int unsigned MR = 4;

    localparam int PM_RANDOM  = 0;
    localparam int PM_SILENT  = 1;
    localparam int PM_EAGER   = 2;
    localparam int PM_ILLEGAL = 3;
    localparam int PM_AT      = 4;

    logic        clk = 1'b0;
    logic        reset, start, p1_valid, p2_valid;
    logic [1:0]  p1_move, p2_move;
    logic        p1_ack, p2_ack, round_active, result_valid, match_done;
    logic [25:0] time_left;
    logic [1:0]  result, winner;
    logic [3:0]  p1_score, p2_score, round_num;

    int checks = 0;
    int errors = 0;

    // reference model: match-level bookkeeping
    int m_p1, m_p2, m_rounds, m_result;

    rps_match_controller #(
        .ROUND_CYCLES(RC),
        .SHOW_CYCLES (SC),
        .WIN_SCORE   (WS),
        .MAX_ROUNDS  (MR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .p1_valid    (p1_valid),
        .p2_valid    (p2_valid),
        .p1_move     (p1_move),
        .p2_move     (p2_move),
        .p1_ack      (p1_ack),
        .p2_ack      (p2_ack),
        .round_active(round_active),
        .time_left   (time_left),
        .result_valid(result_valid),
        .result      (result),
        .p1_score    (p1_score),
        .p2_score    (p2_score),
        .round_num   (round_num),
        .match_done  (match_done),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] gen(input int mode, input logic [1:0] fav,
                                       input int at, input int k);
        logic [1:0] r;
        r = 2'($urandom_range(0, 3));
        case (mode)
            PM_RANDOM:  return {($urandom_range(0, 2) == 0), r};
            PM_SILENT:  return {1'b0, r};
            PM_EAGER:   return {1'b1, fav};
            PM_ILLEGAL: return {1'b1, 2'b11};
            default:    return {(k == at), fav};
        endcase
    endfunction

    task automatic check_static(input string tag);
        chk({tag, "_p1_score"}, p1_score, m_p1);
        chk({tag, "_p2_score"}, p2_score, m_p2);
        chk({tag, "_round_num"}, round_num, m_rounds);
        chk({tag, "_result"}, result, m_result);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_p1_ack"}, p1_ack, 0);
        chk({tag, "_p2_ack"}, p2_ack, 0);
        chk({tag, "_round_active"}, round_active, 0);
        chk({tag, "_time_left"}, time_left, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_match_done"}, match_done, 0);
        chk({tag, "_winner"}, winner, 0);
        check_static(tag);
    endtask

    task automatic start_match();
        start = 1'b1;
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        tick();
        start = 1'b0;
        m_p1 = 0; m_p2 = 0; m_rounds = 0; m_result = 0;
    endtask

    // Plays one round from the first ROUND cycle through the end of SHOW.
    task automatic play_round(input int md1, input logic [1:0] f1, input int at1,
                              input int md2, input logic [1:0] f2, input int at2);
        bit got1 = 0, got2 = 0, ended = 0, e1, e2;
        int mv1 = 0, mv2 = 0, d, exp_res;
        for (int k = 0; k < int'(RC) && !ended; k++) begin
            {p1_valid, p1_move} = gen(md1, f1, at1, k);
            {p2_valid, p2_move} = gen(md2, f2, at2, k);
            start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            e1 = p1_valid && !got1 && (p1_move != 2'b11);
            e2 = p2_valid && !got2 && (p2_move != 2'b11);
            chk("round_active", round_active, 1);
            chk("time_left", time_left, RC - 1 - k);
            chk("p1_ack", p1_ack, e1);
            chk("p2_ack", p2_ack, e2);
            chk("round_result_valid", result_valid, 0);
            check_static("round");
            if (e1) begin got1 = 1; mv1 = int'(p1_move); end
            if (e2) begin got2 = 1; mv2 = int'(p2_move); end
            ended = (got1 && got2) || (k == int'(RC) - 1);
            tick();
        end
        if (got1 && got2) begin
            d = (mv1 - mv2 + 3) % 3;
            exp_res = (d == 0) ? 0 : (d == 1) ? 1 : 2;
        end else if (got1) exp_res = 1;
        else if (got2) exp_res = 2;
        else exp_res = 0;
        m_result = exp_res;

        {p1_valid, p1_move} = {1'b1, 2'($urandom_range(0, 2))};
        {p2_valid, p2_move} = {1'b1, 2'($urandom_range(0, 2))};
        start = ($urandom_range(0, 1) == 0);
        @(negedge clk);
        chk("resolve_valid", result_valid, 1);
        chk("resolve_p1_ack", p1_ack, 0);
        chk("resolve_p2_ack", p2_ack, 0);
        chk("resolve_round_active", round_active, 0);
        chk("resolve_time_left", time_left, 0);
        check_static("resolve");
        if (exp_res == 1 && m_p1 < int'(WS)) m_p1++;
        if (exp_res == 2 && m_p2 < int'(WS)) m_p2++;
        m_rounds++;
        tick();

        for (int s = 0; s < int'(SC); s++) begin
            p1_valid = ($urandom_range(0, 1) == 0);
            p2_valid = ($urandom_range(0, 1) == 0);
            start = ($urandom_range(0, 1) == 0);
            @(negedge clk);
            chk("show_valid", result_valid, 0);
            chk("show_round_active", round_active, 0);
            chk("show_p1_ack", p1_ack, 0);
            chk("show_match_done", match_done, 0);
            check_static("show");
            tick();
        end
        start = 1'b0;
        p1_valid = 1'b0;
        p2_valid = 1'b0;
    endtask

    function automatic bit model_done();
        return (m_p1 == int'(WS)) || (m_p2 == int'(WS)) || (m_rounds == int'(MR));
    endfunction

    task automatic check_done();
        int w;
        w = (m_p1 > m_p2) ? 1 : (m_p2 > m_p1) ? 2 : 0;
        for (int h = 0; h < 3; h++) begin
            p1_valid = 1'b1;
            p1_move  = 2'b00;
            @(negedge clk);
            chk("done_match_done", match_done, 1);
            chk("done_winner", winner, w);
            chk("done_round_active", round_active, 0);
            chk("done_p1_ack", p1_ack, 0);
            check_static("done");
            tick();
        end
        p1_valid = 1'b0;
    endtask

    task automatic finish_random();
        for (int r = 0; r < int'(MR) && !model_done(); r++)
            play_round($urandom_range(0, 4), 2'($urandom_range(0, 2)), $urandom_range(0, 7),
                       $urandom_range(0, 4), 2'($urandom_range(0, 2)), $urandom_range(0, 7));
        chk("match_ended", model_done(), 1);
        check_done();
    endtask

    initial begin
        reset = 1'b1; start = 1'b1;
        p1_valid = 1'b0; p2_valid = 1'b0; p1_move = 2'b00; p2_move = 2'b00;
        m_p1 = 0; m_p2 = 0; m_rounds = 0; m_result = 0;
        tick(); tick();
        @(negedge clk);
        check_zero("reset");
        reset = 1'b0; start = 1'b0;
        tick();

        // P1 rock at cycle 2, P2 scissors at cycle 3, then P1 paper vs rock
        start_match();
        play_round(PM_AT, 2'b00, 1, PM_AT, 2'b10, 2);
        play_round(PM_AT, 2'b01, 0, PM_EAGER, 2'b00, 0);
        chk("matchA_done", model_done(), 1);
        check_done();

        // forfeits, silence, illegal code, held valid
        start_match();
        play_round(PM_SILENT, 2'b00, 0, PM_EAGER, 2'b01, 0);
        play_round(PM_SILENT, 2'b00, 0, PM_SILENT, 2'b00, 0);
        play_round(PM_ILLEGAL, 2'b00, 0, PM_SILENT, 2'b00, 0);
        play_round(PM_EAGER, 2'b00, 0, PM_AT, 2'b01, 4);
        chk("matchB_done", model_done(), 1);
        check_done();

        // four simultaneous ties reach the round limit
        start_match();
        for (int r = 0; r < int'(MR); r++) begin
            logic [1:0] mv;
            mv = 2'($urandom_range(0, 2));
            play_round(PM_EAGER, mv, 0, PM_EAGER, mv, 0);
        end
        chk("matchC_done", model_done(), 1);
        check_done();

        // reset with a latched P1 move must not leak into the next match
        start_match();
        p1_valid = 1'b1; p1_move = 2'b00;
        @(negedge clk);
        chk("pre_reset_ack", p1_ack, 1);
        tick();
        p1_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_p1 = 0; m_p2 = 0; m_rounds = 0; m_result = 0;
        @(negedge clk);
        check_zero("midreset");
        tick();
        start_match();
        play_round(PM_SILENT, 2'b00, 0, PM_EAGER, 2'b10, 0);
        finish_random();

        for (int m = 0; m < 6; m++) begin
            start_match();
            finish_random();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
